instr_fetch_queue: RTL and testbench

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

---
 rtl/instr_fetch_queue_pkg.sv | 21 ++
 rtl/instr_fetch_queue_fifo.sv | 50 +++++
 rtl/instr_fetch_queue.sv | 85 ++++++++
 tb/tb_instr_fetch_queue.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_queue_pkg.sv
// Shared instruction-format definitions for the fetch queue.
// 9-bit word: opcode [8:6], ra [5:3], rb [2:0]; the all-zero word is HLT.
package instr_fetch_queue_pkg;
  localparam int INSTR_W = 9;
  localparam int OP_MSB  = 8;
  localparam int OP_LSB  = 6;
  localparam int RA_MSB  = 5;
  localparam int RA_LSB  = 3;
  localparam int RB_MSB  = 2;
  localparam int RB_LSB  = 0;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  localparam logic [INSTR_W-1:0] HLT_WORD = '0;

  function automatic logic is_hlt(input logic [INSTR_W-1:0] word);
    return word == HLT_WORD;
  endfunction
endpackage

// File: rtl/instr_fetch_queue_fifo.sv
// Synchronous DEPTH-entry FIFO of {pc, instr}; head is read straight from storage.
// Flush wins over push and pop; the caller guarantees no push when full or pop when empty.
module ifq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 17
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign head = mem[rd_ptr];

  // Storage carries no reset; validity is tracked purely by count.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch PC, single in-flight memory request tracker, halt control and decode queue.
// Issue-to-dec_valid is 2 cycles; fetch throttles on queue occupancy plus in-flight.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 8
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_rd,
  output logic [AW-1:0]      imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect,
  input  logic [AW-1:0]      redirect_pc,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [AW-1:0]      dec_pc,
  output logic [2:0]         dec_op,
  output logic [2:0]         dec_ra,
  output logic [2:0]         dec_rb,
  output logic               halted
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = AW + INSTR_W;

  logic [AW-1:0] pc;
  logic [AW-1:0] inflight_pc;
  logic          inflight;
  logic [CW-1:0] count;
  logic [CW-1:0] pending;
  logic [EW-1:0] head;
  logic          push;
  logic          pop;
  logic          hlt_arrive;

  assign push       = inflight && !redirect;
  assign hlt_arrive = push && is_hlt(imem_data);
  assign pending    = count + CW'(inflight);
  assign pop        = dec_valid && dec_ready;

  // Blocking issue while a HLT lands keeps any later word out of the queue.
  assign imem_rd   = !reset && !halted && !redirect && !hlt_arrive && (pending < CW'(DEPTH));
  assign imem_addr = pc;

  ifq_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({inflight_pc, imem_data}),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .count     (count)
  );

  assign dec_valid = (count != '0);
  assign dec_pc    = dec_valid ? head[EW-1:INSTR_W]    : '0;
  assign dec_op    = dec_valid ? head[OP_MSB:OP_LSB]   : '0;
  assign dec_ra    = dec_valid ? head[RA_MSB:RA_LSB]   : '0;
  assign dec_rb    = dec_valid ? head[RB_MSB:RB_LSB]   : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      halted      <= 1'b0;
    end else if (redirect) begin
      pc       <= redirect_pc;
      inflight <= 1'b0;
      halted   <= 1'b0;
    end else begin
      inflight <= imem_rd;
      if (imem_rd) begin
        pc          <= pc + 1'b1;
        inflight_pc <= pc;
      end
      if (hlt_arrive) halted <= 1'b1;
    end
  end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench: synchronous memory model plus hand-computed cycle-by-cycle expectations.
module tb_instr_fetch_queue;
  logic       clk = 1'b0;
  logic       reset;
  logic       imem_rd;
  logic [7:0] imem_addr;
  logic [8:0] imem_data = 9'h100;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic       dec_valid;
  logic       dec_ready;
  logic [7:0] dec_pc;
  logic [2:0] dec_op;
  logic [2:0] dec_ra;
  logic [2:0] dec_rb;
  logic       halted;

  logic [8:0] mem [256];
  int checks = 0;
  int errors = 0;

  instr_fetch_queue #(.DEPTH(4), .AW(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_rd     (imem_rd),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_pc      (dec_pc),
    .dec_op      (dec_op),
    .dec_ra      (dec_ra),
    .dec_rb      (dec_rb),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // Read data appears the cycle after the request.
  always @(posedge clk) begin
    if (imem_rd) imem_data <= mem[imem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    dec_ready   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    for (int a = 0; a < 256; a++) mem[a] = {1'b1, 8'(a)};
    mem[1] = 9'b111001000;
    mem[2] = 9'b110011011;
    step();
    step();

    // Reset state
    check("rst_rd",     imem_rd,   0);
    check("rst_addr",   imem_addr, 0);
    check("rst_vld",    dec_valid, 0);
    check("rst_pc",     dec_pc,    0);
    check("rst_op",     dec_op,    0);
    check("rst_ra",     dec_ra,    0);
    check("rst_rb",     dec_rb,    0);
    check("rst_halted", halted,    0);

    // Streaming with dec_ready high: one issue per cycle, dec lags issue by 2
    dec_ready = 1'b1;
    reset     = 1'b0;
    #1;
    for (int t = 0; t < 7; t++) begin
      check("str_rd",   imem_rd,   1);
      check("str_addr", imem_addr, t);
      if (t < 2) begin
        check("str_vld_lo", dec_valid, 0);
      end else begin
        check("str_vld", dec_valid, 1);
        check("str_pc",  dec_pc,    t - 2);
      end
      if (t == 3) begin
        check("dec1_op", dec_op, 7);
        check("dec1_ra", dec_ra, 1);
        check("dec1_rb", dec_rb, 0);
      end
      if (t == 4) begin
        check("dec2_op", dec_op, 6);
        check("dec2_ra", dec_ra, 3);
        check("dec2_rb", dec_rb, 3);
      end
      step();
    end

    // Backpressure to saturation, then drain into a HLT at address 5
    reset     = 1'b1;
    dec_ready = 1'b0;
    mem[5]    = 9'b000000000;
    step();
    reset = 1'b0;
    repeat (10) step();
    check("full_rd",  imem_rd,   0);
    check("full_vld", dec_valid, 1);
    check("full_pc",  dec_pc,    0);
    dec_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("drain_vld", dec_valid, 1);
      check("drain_pc",  dec_pc,    i);
      step();
    end
    check("hlt_vld",    dec_valid, 1);
    check("hlt_pc",     dec_pc,    5);
    check("hlt_op",     dec_op,    0);
    check("hlt_halted", halted,    1);
    check("hlt_rd",     imem_rd,   0);
    step();
    for (int i = 0; i < 4; i++) begin
      check("post_hlt_vld",    dec_valid, 0);
      check("post_hlt_rd",     imem_rd,   0);
      check("post_hlt_halted", halted,    1);
      step();
    end

    // Redirect out of halt
    redirect    = 1'b1;
    redirect_pc = 8'h08;
    #1;
    check("redir_rd_lo", imem_rd, 0);
    step();
    redirect = 1'b0;
    mem[5]   = 9'h105;
    #1;
    check("resume_halted", halted,    0);
    check("resume_rd",     imem_rd,   1);
    check("resume_addr",   imem_addr, 8'h08);
    step();
    check("resume_addr2", imem_addr, 8'h09);
    step();
    check("resume_vld", dec_valid, 1);
    check("resume_pc",  dec_pc,    8'h08);

    // Redirect with 3 queued, one in flight, and a simultaneous pop
    reset     = 1'b1;
    dec_ready = 1'b0;
    step();
    reset = 1'b0;
    repeat (4) step();
    check("q3_rd",  imem_rd,   0);
    check("q3_vld", dec_valid, 1);
    check("q3_pc",  dec_pc,    0);
    redirect    = 1'b1;
    redirect_pc = 8'h20;
    dec_ready   = 1'b1;
    step();
    redirect = 1'b0;
    #1;
    check("flush_vld",  dec_valid, 0);
    check("flush_rd",   imem_rd,   1);
    check("flush_addr", imem_addr, 8'h20);
    step();
    check("flush_vld2",  dec_valid, 0);
    check("flush_addr2", imem_addr, 8'h21);
    step();
    check("flush_first_vld", dec_valid, 1);
    check("flush_first_pc",  dec_pc,    8'h20);

    // Reset pulse with 2 entries queued and one in flight
    reset     = 1'b1;
    dec_ready = 1'b0;
    step();
    reset = 1'b0;
    repeat (3) step();
    check("pre_rst_vld", dec_valid, 1);
    check("pre_rst_pc",  dec_pc,    0);
    reset = 1'b1;
    #1;
    check("mid_rst_vld",  dec_valid, 0);
    check("mid_rst_rd",   imem_rd,   0);
    check("mid_rst_addr", imem_addr, 0);
    check("mid_rst_pc",   dec_pc,    0);
    step();
    reset     = 1'b0;
    dec_ready = 1'b1;
    #1;
    check("rel_rd",   imem_rd,   1);
    check("rel_addr", imem_addr, 0);
    check("rel_vld0", dec_valid, 0);
    step();
    check("rel_vld1", dec_valid, 0);
    step();
    check("rel_vld2", dec_valid, 1);
    check("rel_pc",   dec_pc,    0);

    // PC wrap from 0xFF to 0x00
    redirect    = 1'b1;
    redirect_pc = 8'hFE;
    step();
    redirect = 1'b0;
    #1;
    check("wrap_addr0", imem_addr, 8'hFE);
    step();
    check("wrap_addr1", imem_addr, 8'hFF);
    step();
    check("wrap_addr2", imem_addr, 8'h00);
    check("wrap_pc0",   dec_pc,    8'hFE);
    step();
    check("wrap_pc1", dec_pc, 8'hFF);
    step();
    check("wrap_vld2", dec_valid, 1);
    check("wrap_pc2",  dec_pc,    8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
